// File: rtl/if_fetch_stage.sv
// Instruction fetch + IF/ID register with a one-entry skid; one instruction per cycle at zero-wait memory; IF_STATS_EN adds counters.
// Latency: ack in cycle N is visible on PC/Instruction in N+1; freeze parks an acked word in the skid and drops imem_req until released.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             branch_taken,
  input  logic [31:0]      branch_addr,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ack,
  output logic [31:0]      PC,
  output logic [31:0]      Instruction,
  output logic             valid,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_ins_q, skid_ins_d;
  logic [31:0] out_pc_q, out_ins_q;
  logic        out_vld_q;
  logic        ld;
  logic [31:0] ld_pc, ld_ins;
  logic        ld_vld;
  logic [31:0] pc_inc;

  assign pc_inc    = pc_q + 32'd4;
  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    skid_pc_d  = skid_pc_q;
    skid_ins_d = skid_ins_q;
    ld         = 1'b0;
    ld_pc      = 32'd0;
    ld_ins     = NOP_INSTR;
    ld_vld     = 1'b0;
    if (branch_taken) begin
      // Flush wins over freeze; any same-cycle ack belongs to the wrong path.
      pc_d    = {branch_addr[31:2], 2'b00};
      state_d = FETCH;
      ld      = 1'b1;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ack) begin
            pc_d = pc_inc;
            if (freeze) begin
              skid_pc_d  = pc_inc;
              skid_ins_d = imem_rdata;
              state_d    = HOLD;
            end else begin
              ld     = 1'b1;
              ld_pc  = pc_inc;
              ld_ins = imem_rdata;
              ld_vld = 1'b1;
            end
          end else if (!freeze) begin
            ld = 1'b1;
          end
        end
        HOLD: begin
          if (!freeze) begin
            ld      = 1'b1;
            ld_pc   = skid_pc_q;
            ld_ins  = skid_ins_q;
            ld_vld  = 1'b1;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      skid_pc_q  <= 32'd0;
      skid_ins_q <= NOP_INSTR;
      out_pc_q   <= 32'd0;
      out_ins_q  <= NOP_INSTR;
      out_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      skid_pc_q  <= skid_pc_d;
      skid_ins_q <= skid_ins_d;
      if (ld) begin
        out_pc_q  <= ld_pc;
        out_ins_q <= ld_ins;
        out_vld_q <= ld_vld;
      end
    end
  end

  assign PC          = out_pc_q;
  assign Instruction = out_ins_q;
  assign valid       = out_vld_q;

`ifdef IF_STATS_EN
  logic [CNT_W-1:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else if (ld) begin
      if (ld_vld && !(&fetch_cnt_q))
        fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
      if (!ld_vld && !(&bubble_cnt_q))
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign fetch_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, wrap/saturation sequence, then randomized run against a queue model.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        rst, freeze, branch_taken, imem_ack;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata, PC, Instruction;
  logic        valid;
  logic [15:0] fetch_cnt, bubble_cnt;

  logic        rst2, ack2, imem_req2, valid2;
  logic [31:0] imem_addr2, imem_rdata2, PC2, Instruction2;
  logic [1:0]  fetch_cnt2, bubble_cnt2;

  logic        rand_mode = 1'b0;
  logic [31:0] rnd_data  = 32'd0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a + 32'hE000_0000;
  endfunction

  assign imem_rdata  = rand_mode ? rnd_data : memf(imem_addr);
  assign imem_rdata2 = memf(imem_addr2);

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .PC(PC),
    .Instruction(Instruction), .valid(valid), .fetch_cnt(fetch_cnt),
    .bubble_cnt(bubble_cnt)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .freeze(1'b0), .branch_taken(1'b0),
    .branch_addr(32'd0), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .imem_ack(ack2), .PC(PC2),
    .Instruction(Instruction2), .valid(valid2), .fetch_cnt(fetch_cnt2),
    .bubble_cnt(bubble_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, frz, br;
    logic [31:0] baddr;
    logic        ack;
    logic        req;
    logic [31:0] addr, pc, ins;
    logic        vld;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic f, input logic b, input logic [31:0] ba,
                     input logic a, input logic rq, input logic [31:0] ad,
                     input logic [31:0] p, input logic [31:0] i, input logic v);
    vec_t t;
    t.rst = r; t.frz = f; t.br = b; t.baddr = ba; t.ack = a;
    t.req = rq; t.addr = ad; t.pc = p; t.ins = i; t.vld = v;
    vq.push_back(t);
  endtask

  // Reference model: fetched-but-undelivered words live in a queue; decode drains it when not frozen.
  logic [31:0] m_pc, m_opc, m_ins;
  logic        m_vld;
  logic [63:0] m_q[$];
  logic [15:0] m_fc, m_bc;

  task automatic model_step(input logic r, input logic f, input logic b,
                            input logic [31:0] ba, input logic a, input logic [31:0] rd);
    logic [63:0] w;
    if (r) begin
      m_pc = 32'd0; m_q.delete(); m_opc = 32'd0; m_ins = NOP; m_vld = 1'b0;
      m_fc = 16'd0; m_bc = 16'd0;
    end else if (b) begin
      m_pc = {ba[31:2], 2'b00}; m_q.delete();
      m_opc = 32'd0; m_ins = NOP; m_vld = 1'b0;
      if (m_bc != 16'hFFFF) m_bc++;
    end else begin
      if (m_q.size() == 0 && a) begin
        m_q.push_back({m_pc + 32'd4, rd});
        m_pc = m_pc + 32'd4;
      end
      if (!f) begin
        if (m_q.size() > 0) begin
          w = m_q.pop_front();
          m_opc = w[63:32]; m_ins = w[31:0]; m_vld = 1'b1;
          if (m_fc != 16'hFFFF) m_fc++;
        end else begin
          m_opc = 32'd0; m_ins = NOP; m_vld = 1'b0;
          if (m_bc != 16'hFFFF) m_bc++;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] a2;
    int          ec;
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0; imem_ack = 1'b0;
    rst2 = 1'b1; ack2 = 1'b0;

    //  rst frz br baddr      ack  req addr          PC            Instruction       vld
    add(1, 0, 0, 32'h0,     0,   1, 32'h0,        32'h0,        NOP,              0);
    add(0, 0, 0, 32'h0,     1,   1, 32'h4,        32'h4,        32'hE000_0000,    1);
    add(0, 0, 0, 32'h0,     1,   1, 32'h8,        32'h8,        32'hE000_0004,    1);
    add(0, 0, 0, 32'h0,     1,   1, 32'hC,        32'hC,        32'hE000_0008,    1);
    add(0, 0, 0, 32'h0,     0,   1, 32'hC,        32'h0,        NOP,              0);
    add(0, 0, 0, 32'h0,     0,   1, 32'hC,        32'h0,        NOP,              0);
    add(0, 0, 0, 32'h0,     1,   1, 32'h10,       32'h10,       32'hE000_000C,    1);
    add(0, 1, 0, 32'h0,     1,   0, 32'h14,       32'h10,       32'hE000_000C,    1);
    add(0, 1, 0, 32'h0,     1,   0, 32'h14,       32'h10,       32'hE000_000C,    1);
    add(0, 1, 0, 32'h0,     1,   0, 32'h14,       32'h10,       32'hE000_000C,    1);
    add(0, 1, 0, 32'h0,     1,   0, 32'h14,       32'h10,       32'hE000_000C,    1);
    add(0, 0, 0, 32'h0,     0,   1, 32'h14,       32'h14,       32'hE000_0010,    1);
    add(0, 0, 0, 32'h0,     1,   1, 32'h18,       32'h18,       32'hE000_0014,    1);
    add(0, 1, 0, 32'h0,     1,   0, 32'h1C,       32'h18,       32'hE000_0014,    1);
    add(0, 1, 1, 32'h103,   0,   1, 32'h100,      32'h0,        NOP,              0);
    add(0, 0, 0, 32'h0,     1,   1, 32'h104,      32'h104,      32'hE000_0100,    1);
    add(0, 0, 1, 32'h200,   1,   1, 32'h200,      32'h0,        NOP,              0);
    add(0, 0, 0, 32'h0,     1,   1, 32'h204,      32'h204,      32'hE000_0200,    1);
    add(0, 1, 0, 32'h0,     1,   0, 32'h208,      32'h204,      32'hE000_0200,    1);
    add(1, 1, 0, 32'h0,     1,   1, 32'h0,        32'h0,        NOP,              0);
    add(0, 0, 0, 32'h0,     1,   1, 32'h4,        32'h4,        32'hE000_0000,    1);
    add(0, 1, 0, 32'h0,     0,   1, 32'h4,        32'h4,        32'hE000_0000,    1);
    add(0, 0, 0, 32'h0,     1,   1, 32'h8,        32'h8,        32'hE000_0004,    1);

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; freeze = vq[i].frz; branch_taken = vq[i].br;
      branch_addr = vq[i].baddr; imem_ack = vq[i].ack;
      @(posedge clk); #1;
      chk($sformatf("v%0d.req", i),   {31'd0, imem_req}, {31'd0, vq[i].req});
      chk($sformatf("v%0d.addr", i),  imem_addr,         vq[i].addr);
      chk($sformatf("v%0d.pc", i),    PC,                vq[i].pc);
      chk($sformatf("v%0d.ins", i),   Instruction,       vq[i].ins);
      chk($sformatf("v%0d.vld", i),   {31'd0, valid},    {31'd0, vq[i].vld});
    end

    // PC wrap at the top of the address space and 2-bit counter saturation.
    rst2 = 1'b1; ack2 = 1'b1;
    @(posedge clk); #1;
    chk("wrap.rst_addr", imem_addr2, 32'hFFFF_FFFC);
    chk("wrap.rst_vld", {31'd0, valid2}, 32'd0);
    chk("wrap.rst_cnt", {30'd0, fetch_cnt2}, 32'd0);
    rst2 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      a2 = 32'hFFFF_FFFC + 32'(4 * k);
      chk($sformatf("wrap%0d.addr", k), imem_addr2, a2);
      chk($sformatf("wrap%0d.pc", k), PC2, a2);
      chk($sformatf("wrap%0d.ins", k), Instruction2, memf(a2 - 32'd4));
`ifdef IF_STATS_EN
      ec = (k > 3) ? 3 : k;
`else
      ec = 0;
`endif
      chk($sformatf("wrap%0d.fcnt", k), {30'd0, fetch_cnt2}, 32'(ec));
      chk($sformatf("wrap%0d.bcnt", k), {30'd0, bubble_cnt2}, 32'd0);
    end

    // Randomized run against the queue model.
    rand_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      rst          = (c == 0) || ($urandom_range(0, 199) == 0);
      branch_taken = ($urandom_range(0, 19) == 0);
      branch_addr  = $urandom;
      freeze       = ($urandom_range(0, 2) == 0);
      imem_ack     = $urandom_range(0, 1) == 1;
      rnd_data     = $urandom;
      model_step(rst, freeze, branch_taken, branch_addr, imem_ack, rnd_data);
      @(posedge clk); #1;
      chk("rnd.req",  {31'd0, imem_req}, {31'd0, m_q.size() == 0});
      chk("rnd.addr", imem_addr, m_pc);
      chk("rnd.pc",   PC, m_opc);
      chk("rnd.ins",  Instruction, m_ins);
      chk("rnd.vld",  {31'd0, valid}, {31'd0, m_vld});
`ifdef IF_STATS_EN
      chk("rnd.fcnt", {16'd0, fetch_cnt}, {16'd0, m_fc});
      chk("rnd.bcnt", {16'd0, bubble_cnt}, {16'd0, m_bc});
`else
      chk("rnd.fcnt", {16'd0, fetch_cnt}, 32'd0);
      chk("rnd.bcnt", {16'd0, bubble_cnt}, 32'd0);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
